// File: rtl/tempo_para_segundos.sv
// tempo_para_segundos
//   Packs a calendar breakdown (anos/meses/dias/horas/minutos/segundos, with a
//   365-day year and a 30-day month) back into a total count of seconds.
//   One field is multiplied and accumulated per clock, under a
//   start/busy/done handshake.
//
//   Optional build macro: VALIDA_CAMPOS_EN
//     defined   -> fields are range-checked when a request is accepted. An
//                  out-of-range field sets erro and skips the arithmetic.
//     undefined -> no range checks are built and erro is tied to 0.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request, accepted only in IDLE
//   anos..segundos  in [W_CAMPO]  input fields
//   busy       out  conversion in progress (states ANO..SEG)
//   done       out  one-cycle pulse, result valid
//   total_seg  out  [W_SEG] result (low W_SEG bits of the full sum)
//   ovf        out  full sum did not fit in W_SEG bits
//   erro       out  field out of range (VALIDA_CAMPOS_EN builds only)
//
// State | meaning
//   IDLE  | waiting for start
//   ANO   | acc += anos    * SEG_ANO
//   MES   | acc += meses   * SEG_MES
//   DIA   | acc += dias    * SEG_DIA
//   HORA  | acc += horas   * 3600
//   MIN   | acc += minutos * 60
//   SEG   | acc += segundos; result registered when leaving this state
//   DONE  | done pulse
module tempo_para_segundos #(
  parameter int W_SEG   = 32,
  parameter int W_CAMPO = 8,
  parameter int SEG_ANO = 31536000,
  parameter int SEG_MES = 2592000,
  parameter int SEG_DIA = 86400
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_CAMPO-1:0] anos,
  input  logic [W_CAMPO-1:0] meses,
  input  logic [W_CAMPO-1:0] dias,
  input  logic [W_CAMPO-1:0] horas,
  input  logic [W_CAMPO-1:0] minutos,
  input  logic [W_CAMPO-1:0] segundos,
  output logic               busy,
  output logic               done,
  output logic [W_SEG-1:0]   total_seg,
  output logic               ovf,
  output logic               erro
);

  // Wide enough that the worst-case sum of all six products never wraps.
  localparam int W_ACC = W_SEG + W_CAMPO + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ANO, S_MES, S_DIA, S_HORA, S_MIN, S_SEG, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [W_ACC-1:0]   acc_q, acc_d;
  logic [W_CAMPO-1:0] anos_q, meses_q, dias_q, horas_q, min_q, seg_q;
  logic [W_CAMPO-1:0] anos_d, meses_d, dias_d, horas_d, min_d, seg_d;
  logic [W_SEG-1:0]   total_q, total_d;
  logic               ovf_q, ovf_d, erro_q, erro_d;

  logic [W_CAMPO-1:0] campo;
  logic [W_ACC-1:0]   peso;
  logic [W_ACC-1:0]   acc_soma;
  logic               campo_inv;

`ifdef VALIDA_CAMPOS_EN
  assign campo_inv = (meses   > W_CAMPO'(11)) || (dias     > W_CAMPO'(29)) ||
                     (horas   > W_CAMPO'(23)) || (minutos  > W_CAMPO'(59)) ||
                     (segundos > W_CAMPO'(59));
`else
  assign campo_inv = 1'b0;
`endif

  // A single shared multiplier: the current state selects the field and its weight.
  always_comb begin
    campo = '0;
    peso  = '0;
    case (state_q)
      S_ANO:  begin campo = anos_q;  peso = W_ACC'(SEG_ANO); end
      S_MES:  begin campo = meses_q; peso = W_ACC'(SEG_MES); end
      S_DIA:  begin campo = dias_q;  peso = W_ACC'(SEG_DIA); end
      S_HORA: begin campo = horas_q; peso = W_ACC'(3600);    end
      S_MIN:  begin campo = min_q;   peso = W_ACC'(60);      end
      S_SEG:  begin campo = seg_q;   peso = W_ACC'(1);       end
      default: ;
    endcase
    acc_soma = acc_q + (W_ACC'(campo) * peso);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    anos_d  = anos_q;
    meses_d = meses_q;
    dias_d  = dias_q;
    horas_d = horas_q;
    min_d   = min_q;
    seg_d   = seg_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    erro_d  = erro_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d  = '0;
          ovf_d  = 1'b0;
          erro_d = campo_inv;
          if (campo_inv) begin
            // Skip the arithmetic: SEG with all-zero fields yields a zero result next edge.
            anos_d = '0; meses_d = '0; dias_d = '0;
            horas_d = '0; min_d = '0; seg_d = '0;
            state_d = S_SEG;
          end else begin
            anos_d = anos; meses_d = meses; dias_d = dias;
            horas_d = horas; min_d = minutos; seg_d = segundos;
            state_d = S_ANO;
          end
        end
      end
      S_ANO:  begin acc_d = acc_soma; state_d = S_MES;  end
      S_MES:  begin acc_d = acc_soma; state_d = S_DIA;  end
      S_DIA:  begin acc_d = acc_soma; state_d = S_HORA; end
      S_HORA: begin acc_d = acc_soma; state_d = S_MIN;  end
      S_MIN:  begin acc_d = acc_soma; state_d = S_SEG;  end
      S_SEG: begin
        acc_d   = acc_soma;
        total_d = acc_soma[W_SEG-1:0];
        ovf_d   = |acc_soma[W_ACC-1:W_SEG];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      anos_q  <= '0;
      meses_q <= '0;
      dias_q  <= '0;
      horas_q <= '0;
      min_q   <= '0;
      seg_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      anos_q  <= anos_d;
      meses_q <= meses_d;
      dias_q  <= dias_d;
      horas_q <= horas_d;
      min_q   <= min_d;
      seg_q   <= seg_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      erro_q  <= erro_d;
    end
  end

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign total_seg = total_q;
  assign ovf       = ovf_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_tempo_para_segundos.sv
module tb_tempo_para_segundos;

  logic        clk, rst_n, start;
  logic [7:0]  anos, meses, dias, horas, minutos, segundos;
  logic        busy, done, ovf, erro;
  logic [31:0] total_seg;

  int vectors = 0;
  int errors  = 0;

  tempo_para_segundos dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .anos(anos), .meses(meses), .dias(dias), .horas(horas),
    .minutos(minutos), .segundos(segundos),
    .busy(busy), .done(done), .total_seg(total_seg), .ovf(ovf), .erro(erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain calendar arithmetic on 64-bit integers.
  task automatic model(input logic [7:0] a, m, d, h, mi, s,
                       output logic [31:0] tot, output logic o,
                       output logic e, output int lat);
    longint unsigned soma;
    e = 1'b0;
`ifdef VALIDA_CAMPOS_EN
    e = (m > 11) || (d > 29) || (h > 23) || (mi > 59) || (s > 59);
`endif
    soma = longint'(a) * 31536000 + longint'(m) * 2592000 + longint'(d) * 86400
         + longint'(h) * 3600 + longint'(mi) * 60 + longint'(s);
    if (e) soma = 0;
    tot = soma[31:0];
    o   = (soma >> 32) != 0;
    lat = e ? 1 : 6;
  endtask

  task automatic run_conv(input logic [7:0] a, m, d, h, mi, s,
                          input bit repulse, input string nome);
    logic [31:0] exp_tot;
    logic exp_ovf, exp_err;
    int exp_lat, lat, extra;
    model(a, m, d, h, mi, s, exp_tot, exp_ovf, exp_err, exp_lat);
    anos = a; meses = m; dias = d; horas = h; minutos = mi; segundos = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    anos = 8'hxx; segundos = 8'hxx;
    vectors++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_accept: got %b want 1", nome, busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (repulse && lat == 2) start = 1'b1;
      if (repulse && lat == 3) start = 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    vectors++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", nome, lat, exp_lat);
    end
    vectors++;
    if (total_seg !== exp_tot) begin
      errors++; $display("FAIL %s total_seg: got %0d want %0d", nome, total_seg, exp_tot);
    end
    vectors++;
    if (ovf !== exp_ovf || erro !== exp_err || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s flags: got ovf=%b erro=%b busy=%b want ovf=%b erro=%b busy=0",
               nome, ovf, erro, busy, exp_ovf, exp_err);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 1'b0) extra++;
    end
    vectors++;
    if (extra != 0) begin
      errors++; $display("FAIL %s extra_done: got %0d pulses want 0", nome, extra);
    end
    vectors++;
    if (total_seg !== exp_tot) begin
      errors++; $display("FAIL %s total_held: got %0d want %0d", nome, total_seg, exp_tot);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    anos = 0; meses = 0; dias = 0; horas = 0; minutos = 0; segundos = 0;
    tick(); tick();
    vectors++;
    if ({busy, done, ovf, erro, total_seg} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b erro=%b total=%0d want all 0",
               busy, done, ovf, erro, total_seg);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_conv(0, 0, 1, 1, 1, 1, 1'b0, "dhms_1");
    run_conv(136, 0, 0, 0, 0, 0, 1'b0, "anos_136");
    run_conv(137, 0, 0, 0, 0, 0, 1'b0, "anos_137_ovf");
    run_conv(1, 2, 3, 4, 5, 6, 1'b1, "mixed_repulse");
    run_conv(0, 0, 0, 0, 60, 0, 1'b0, "minutos_60");
    run_conv(0, 12, 0, 0, 0, 0, 1'b0, "meses_12");
    run_conv(255, 255, 255, 255, 255, 255, 1'b0, "all_max");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      if (i % 2 == 0)
        run_conv(8'($urandom_range(0, 255)), 8'($urandom_range(0, 11)),
                 8'($urandom_range(0, 29)), 8'($urandom_range(0, 23)),
                 8'($urandom_range(0, 59)), 8'($urandom_range(0, 59)),
                 1'($urandom_range(0, 1)), "random_inrange");
      else
        run_conv(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "random_full");
    end
  endtask

  task automatic test_midreset();
    int dones;
    anos = 3; meses = 4; dias = 5; horas = 6; minutos = 7; segundos = 8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, ovf, erro, total_seg} !== 36'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b ovf=%b erro=%b total=%0d want all 0",
               busy, done, ovf, erro, total_seg);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done !== 1'b0) dones++;
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0) dones++;
    end
    vectors++;
    if (dones != 0) begin
      errors++; $display("FAIL midreset_no_done: got %0d pulses want 0", dones);
    end
    run_conv(0, 0, 0, 0, 0, 59, 1'b0, "after_reset_59");
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_tot;
    logic exp_ovf, exp_err, prev_done;
    int exp_lat, ndone, last, gap_bad, busy_bad, tot_bad;
    logic [7:0] a, m, d, h, mi, s;
    a = 8'($urandom); m = 8'($urandom_range(0, 11)); d = 8'($urandom_range(0, 29));
    h = 8'($urandom_range(0, 23)); mi = 8'($urandom_range(0, 59)); s = 8'($urandom_range(0, 59));
    model(a, m, d, h, mi, s, exp_tot, exp_ovf, exp_err, exp_lat);
    anos = a; meses = m; dias = d; horas = h; minutos = mi; segundos = s;
    start = 1'b1;
    prev_done = 1'b0; ndone = 0; last = -1; gap_bad = 0; busy_bad = 0; tot_bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy !== !(done || prev_done)) busy_bad++;
      if (done === 1'b1) begin
        ndone++;
        if (last >= 0 && c - last != 8) gap_bad++;
        if (total_seg !== exp_tot || ovf !== exp_ovf) tot_bad++;
        last = c;
      end
      prev_done = done;
    end
    start = 1'b0;
    vectors++;
    if (ndone < 4) begin
      errors++; $display("FAIL b2b_count: got %0d done pulses want >=4", ndone);
    end
    vectors++;
    if (gap_bad != 0) begin
      errors++; $display("FAIL b2b_spacing: got %0d gaps not 8 want 0", gap_bad);
    end
    vectors++;
    if (busy_bad != 0) begin
      errors++; $display("FAIL b2b_busy: got %0d bad busy cycles want 0", busy_bad);
    end
    vectors++;
    if (tot_bad != 0) begin
      errors++; $display("FAIL b2b_total: got %0d wrong results want 0 (expected %0d)",
                         tot_bad, exp_tot);
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
